// File: rtl/lpc_record_packer.sv
// lpc_record_packer: captures decoded LPC records on each rising edge of the
// decoder's record-complete level, queues them in a small FIFO and streams
// each one out as six bytes over a valid/ready byte interface.
`timescale 1ns/1ps
module lpc_record_packer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  in_cyctype_dir,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic        in_clock_enable,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int unsigned REC_W    = 44;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned LAST_IDX = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_e;

    // Record slots; layout {cyctype_dir[43:40], addr[39:8], data[7:0]}
    logic [REC_W-1:0] mem_q [FIFO_DEPTH];

    logic             prev_ce_q, prev_ce_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    state_e           state_q, state_d;
    logic [REC_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;

    logic             capture_c;
    logic             full_c;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;
    logic [REC_W-1:0] rec_in_c;
    logic [REC_W-1:0] rec_head_c;

    // Byte at position idx of a held record
    function automatic logic [7:0] byte_sel(input logic [REC_W-1:0] rec,
                                            input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {4'h5, rec[43:40]};
            3'd1:    b = rec[39:32];
            3'd2:    b = rec[31:24];
            3'd3:    b = rec[23:16];
            3'd4:    b = rec[15:8];
            default: b = rec[7:0];
        endcase
        return b;
    endfunction

    // Capture edge detect and FIFO push/pop/drop bookkeeping
    always_comb begin
        capture_c    = in_clock_enable & ~prev_ce_q;
        full_c       = (count_q == CNT_W'(FIFO_DEPTH));
        push_c       = capture_c & ~full_c;
        drop_c       = capture_c & full_c;
        pop_c        = (state_q == ST_LOAD);
        rec_in_c     = {in_cyctype_dir, in_addr, in_data};
        rec_head_c   = mem_q[rd_ptr_q];

        prev_ce_d    = in_clock_enable;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop_c) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    // Serializer next-state and registered byte outputs
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (count_q != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                hold_d      = rec_head_c;
                idx_d       = '0;
                out_byte_d  = byte_sel(rec_head_c, 3'd0);
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        out_byte_d = byte_sel(hold_q, idx_q + IDX_W'(1));
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Record storage; contents are don't-care until written
    always_ff @(posedge lpc_clock) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= rec_in_c;
        end
    end

    // State registers; prev_ce resets high so a level already up is ignored
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            prev_ce_q    <= 1'b1;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            idx_q        <= '0;
            out_byte_q   <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            prev_ce_q    <= prev_ce_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            idx_q        <= idx_d;
            out_byte_q   <= out_byte_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_byte   = out_byte_q;
    assign out_valid  = out_valid_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_lpc_record_packer.sv
// Directed bench for lpc_record_packer: table-driven single records plus
// hand-written backpressure, overflow, full-with-pop, level-hold and reset cases.
`timescale 1ns/1ps
module tb_lpc_record_packer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_cyctype_dir;
    logic [31:0] in_addr;
    logic [7:0]  in_data;
    logic        in_clock_enable;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [7:0]  drop_count;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [7:0]  d;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [4];

    lpc_record_packer #(.FIFO_DEPTH(4)) dut (
        .lpc_clock       (clk),
        .lpc_reset       (rst_n),
        .in_cyctype_dir  (in_cyctype_dir),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .in_clock_enable (in_clock_enable),
        .out_byte        (out_byte),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .overflow        (overflow),
        .drop_count      (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Records used in the multi-record cases
    function automatic logic [3:0] rc(input int i);
        return 4'(i + 1);
    endfunction
    function automatic logic [31:0] ra(input int i);
        return 32'h1000_0000 * 32'(i + 1) + 32'h0000_0010 * 32'(i + 1);
    endfunction
    function automatic logic [7:0] rd(input int i);
        return 8'(8'hA0 + i);
    endfunction
    function automatic logic [47:0] rexp(input int i);
        return {4'h5, rc(i), ra(i), rd(i)};
    endfunction

    // Drive one rising edge of in_clock_enable, then scramble the payload
    task automatic capture(input logic [3:0] c, input logic [31:0] a, input logic [7:0] d);
        in_cyctype_dir  = c;
        in_addr         = a;
        in_data         = d;
        in_clock_enable = 1'b1;
        step();
        in_clock_enable = 1'b0;
        in_cyctype_dir  = 4'($urandom);
        in_addr         = $urandom;
        in_data         = 8'($urandom);
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Wait (bounded) for a record, then require its six bytes back to back
    task automatic expect_record(input string name, input logic [47:0] exp, input int budget);
        int n;
        logic [7:0] b;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        check($sformatf("%s start", name), 48'(out_valid), 48'd1);
        for (int k = 0; k < 6; k++) begin
            b = exp[47 - 8*k -: 8];
            check($sformatf("%s b%0d", name, k), {39'd0, out_valid, out_byte}, {39'd0, 1'b1, b});
            step();
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            if (out_valid) seen++;
            step();
        end
        check(name, 48'(seen), 48'd0);
    endtask

    initial begin
        vecs[0] = '{c: 4'h2, a: 32'h0000_0080, d: 8'h3C, exp: 48'h52_00_00_00_80_3C};
        vecs[1] = '{c: 4'hF, a: 32'hDEAD_BEEF, d: 8'hA5, exp: 48'h5F_DE_AD_BE_EF_A5};
        vecs[2] = '{c: 4'h0, a: 32'h1234_5678, d: 8'h00, exp: 48'h50_12_34_56_78_00};
        vecs[3] = '{c: 4'h7, a: 32'hFFFF_0001, d: 8'h81, exp: 48'h57_FF_FF_00_01_81};

        rst_n           = 1'b0;
        in_cyctype_dir  = '0;
        in_addr         = '0;
        in_data         = '0;
        in_clock_enable = 1'b0;
        out_ready       = 1'b1;
        step();
        step();
        check("reset out_valid",  48'(out_valid),  48'd0);
        check("reset out_byte",   48'(out_byte),   48'd0);
        check("reset overflow",   48'(overflow),   48'd0);
        check("reset drop_count", 48'(drop_count), 48'd0);
        rst_n = 1'b1;
        step();

        // Single records with exact latency: idle at N+2, byte 0 at N+3
        for (int i = 0; i < 4; i++) begin
            capture(vecs[i].c, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d N+2 idle", i), 48'(out_valid), 48'd0);
            step();
            expect_record($sformatf("vec%0d", i), vecs[i].exp, 0);
            check($sformatf("vec%0d end", i), 48'(out_valid), 48'd0);
            step();
        end

        // Backpressure while byte 2 is presented
        capture(4'h3, 32'h1122_3344, 8'h55);
        step();
        check("bp b0", {39'd0, out_valid, out_byte}, {39'd0, 1'b1, 8'h53});
        step();
        check("bp b1", {39'd0, out_valid, out_byte}, {39'd0, 1'b1, 8'h11});
        step();
        check("bp b2", {39'd0, out_valid, out_byte}, {39'd0, 1'b1, 8'h22});
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp hold%0d", k), {39'd0, out_valid, out_byte}, {39'd0, 1'b1, 8'h22});
        end
        out_ready = 1'b1;
        step();
        check("bp b3", {39'd0, out_valid, out_byte}, {39'd0, 1'b1, 8'h33});
        step();
        check("bp b4", {39'd0, out_valid, out_byte}, {39'd0, 1'b1, 8'h44});
        step();
        check("bp b5", {39'd0, out_valid, out_byte}, {39'd0, 1'b1, 8'h55});
        step();
        check("bp end", 48'(out_valid), 48'd0);

        // Overflow: record 0 goes to the serializer (stalled), then six more
        // captures fill the 4 slots and drop the last two
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) capture(rc(i), ra(i), rd(i));
        check("ovf overflow",   48'(overflow),   48'd1);
        check("ovf drop_count", 48'(drop_count), 48'd2);
        check("ovf stalled b0", {39'd0, out_valid, out_byte}, {39'd0, 1'b1, rexp(0)[47:40]});
        expect_record("ovf held", rexp(0), 10);
        for (int i = 1; i < 5; i++) expect_record($sformatf("ovf fifo%0d", i), rexp(i), 10);
        expect_idle("ovf no extra", 20);

        // Full FIFO with a capture landing in the serializer's pop cycle
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) capture(rc(i), ra(i), rd(i));
        check("fullpop pre drop", 48'(drop_count), 48'd0);
        expect_record("fullpop held", rexp(0), 10);
        out_ready = 1'b0;
        step();
        check("fullpop load idle", 48'(out_valid), 48'd0);
        capture(rc(5), ra(5), rd(5));
        check("fullpop drop_count", 48'(drop_count), 48'd1);
        check("fullpop overflow",   48'(overflow),   48'd1);
        for (int i = 1; i < 5; i++) expect_record($sformatf("fullpop fifo%0d", i), rexp(i), 10);
        expect_idle("fullpop no extra", 20);

        // Level held high through reset release: no capture until a new edge
        in_clock_enable = 1'b1;
        apply_reset();
        expect_idle("lvl after release", 10);
        in_clock_enable = 1'b0;
        step();
        in_cyctype_dir  = 4'hA;
        in_addr         = 32'h0BAD_F00D;
        in_data         = 8'h77;
        in_clock_enable = 1'b1;
        step();
        in_cyctype_dir  = 4'h1;
        in_addr         = 32'h5555_5555;
        in_data         = 8'h99;
        expect_record("lvl record", 48'h5A_0B_AD_F0_0D_77, 5);
        expect_idle("lvl single capture", 15);
        in_clock_enable = 1'b0;

        // Reset asserted while byte 3 of a record is on the bus
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) capture(rc(i), ra(i), rd(i));
        check("mid pre drop", 48'(drop_count), 48'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("mid b3", {39'd0, out_valid, out_byte}, {39'd0, 1'b1, rexp(0)[23:16]});
        #3;
        rst_n = 1'b0;
        #1;
        check("mid async valid",    48'(out_valid),  48'd0);
        check("mid async byte",     48'(out_byte),   48'd0);
        check("mid async overflow", 48'(overflow),   48'd0);
        check("mid async drops",    48'(drop_count), 48'd0);
        step();
        step();
        rst_n = 1'b1;
        expect_idle("mid no output", 20);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
